tetris_game_ctrl: RTL and testbench

Single-clock, parametrised top-level game controller for the Tetris chip. It sequences board wipe, piece generation, gravity-driven movement, landing and multi-row clearing. It also tracks cleared lines and game-over. It sits above the board/piece datapath and talks to it through request/acknowledge handshakes. Unlike the earlier controller, it clears any number of full rows per landing, generates its own gravity ticks and detects a blocked spawn.

---
 rtl/tetris_game_ctrl.sv | 177 +++++++++++++++++
 tb/tb_tetris_game_ctrl.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/tetris_game_ctrl.sv
// tetris_game_ctrl: top-level game sequencer for the Tetris chip.
// Drives board wipe, piece generation, gravity ticks, landing and
// multi-row clearing through level-based request/ack handshakes with
// the board/piece datapath. Tracks cleared lines (saturating) and
// game-over. All outputs are Moore, decoded from registered state.
//
// Optional feature macro: LEVEL_SPEEDUP_EN
//   defined   -> level rises every 8 cleared lines (max 7) and the
//                gravity period halves per level (minimum 1), latched
//                on each MOVE entry.
//   undefined -> level tied to 0, gravity period fixed at GRAV_PERIOD.

module tetris_game_ctrl #(
    parameter int ROWS        = 12,
    parameter int RW          = 4,
    parameter int GRAV_W      = 16,
    parameter int GRAV_PERIOD = 1000,
    parameter int LINES_W     = 8
) (
    input  logic               clka,
    input  logic               restart,
    input  logic               gen_ack,
    input  logic               spawn_ok,
    input  logic               touched,
    input  logic [ROWS-1:0]    full_rows,
    input  logic               clr_done,
    output logic [2:0]         state,
    output logic               board_clr,
    output logic               gen_req,
    output logic               drop_tick,
    output logic               clr_req,
    output logic [RW-1:0]      clr_row,
    output logic [LINES_W-1:0] lines,
    output logic [2:0]         level,
    output logic               game_over
);

    typedef enum logic [2:0] {
        S_NEWBOARD = 3'd0,
        S_GEN      = 3'd1,
        S_MOVE     = 3'd2,
        S_LAND     = 3'd3,
        S_CLEAR    = 3'd4,
        S_OVER     = 3'd5
    } state_t;

    localparam logic [GRAV_W-1:0]  PERIOD_BASE = GRAV_W'(GRAV_PERIOD);
    localparam logic [LINES_W-1:0] LINES_MAX   = '1;

    state_t             state_q, state_d;
    logic [GRAV_W-1:0]  grav_q, grav_d;
    logic [ROWS-1:0]    mask_q, mask_d;
    logic [LINES_W-1:0] lines_q, lines_d;
    logic [GRAV_W-1:0]  period;
    logic               at_tc;
    logic [RW-1:0]      low_idx;

`ifdef LEVEL_SPEEDUP_EN
    logic [2:0]         level_q, level_d;
    logic [GRAV_W-1:0]  period_q, period_d;
    logic [GRAV_W-1:0]  period_shift;
    logic [31:0]        lines_inc;

    assign period_shift = PERIOD_BASE >> level_q;
    assign lines_inc    = 32'(lines_q) + 32'd1;
    assign period       = period_q;
    assign level        = level_q;
`else
    assign period       = PERIOD_BASE;
    assign level        = 3'd0;
`endif

    // Terminal count of the gravity counter for the current period.
    assign at_tc = (grav_q == period - GRAV_W'(1));

    // Lowest set index of the pending mask: topmost full row is cleared first,
    // so datapath shifts never move rows still waiting at higher indices.
    always_comb begin
        low_idx = '0;
        for (int i = ROWS - 1; i >= 0; i--) begin
            if (mask_q[i]) low_idx = RW'(i);
        end
    end

    // Next-state and Moore output decode.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // through the case can leave one unassigned and infer a latch.
        state_d   = state_q;
        grav_d    = grav_q;
        mask_d    = mask_q;
        lines_d   = lines_q;
        board_clr = 1'b0;
        gen_req   = 1'b0;
        drop_tick = 1'b0;
        clr_req   = 1'b0;
        game_over = 1'b0;
`ifdef LEVEL_SPEEDUP_EN
        level_d   = level_q;
        period_d  = period_q;
`endif
        case (state_q)
            S_NEWBOARD: begin
                board_clr = 1'b1;
                state_d   = S_GEN;
            end
            S_GEN: begin
                gen_req = 1'b1;
                if (gen_ack) begin
                    grav_d  = '0;
`ifdef LEVEL_SPEEDUP_EN
                    period_d = (period_shift == '0) ? GRAV_W'(1) : period_shift;
`endif
                    state_d = spawn_ok ? S_MOVE : S_OVER;
                end
            end
            S_MOVE: begin
                drop_tick = at_tc;
                grav_d    = at_tc ? '0 : grav_q + GRAV_W'(1);
                if (touched) state_d = S_LAND;
            end
            S_LAND: begin
                mask_d  = full_rows;
                state_d = (full_rows == '0) ? S_GEN : S_CLEAR;
            end
            S_CLEAR: begin
                clr_req = 1'b1;
                if (clr_done) begin
                    // Drop the lowest set bit.
                    mask_d = mask_q & (mask_q - ROWS'(1));
                    if (lines_q != LINES_MAX) begin
                        lines_d = lines_q + LINES_W'(1);
`ifdef LEVEL_SPEEDUP_EN
                        if ((lines_inc[2:0] == 3'd0) && (level_q != 3'd7))
                            level_d = level_q + 3'd1;
`endif
                    end
                    if (mask_d == '0) state_d = S_GEN;
                end
            end
            S_OVER: begin
                game_over = 1'b1;
            end
            default: state_d = S_NEWBOARD;
        endcase
    end

    // State, counter, mask and score registers with synchronous restart.
    always_ff @(posedge clka) begin
        // NOTE: non-blocking assignments so every register samples the
        // pre-edge values, independent of statement order.
        if (restart) begin
            state_q <= S_NEWBOARD;
            grav_q  <= '0;
            mask_q  <= '0;
            lines_q <= '0;
`ifdef LEVEL_SPEEDUP_EN
            level_q  <= 3'd0;
            period_q <= PERIOD_BASE;
`endif
        end else begin
            state_q <= state_d;
            grav_q  <= grav_d;
            mask_q  <= mask_d;
            lines_q <= lines_d;
`ifdef LEVEL_SPEEDUP_EN
            level_q  <= level_d;
            period_q <= period_d;
`endif
        end
    end

    assign state   = state_q;
    assign clr_row = low_idx;
    assign lines   = lines_q;

endmodule

// File: tb/tb_tetris_game_ctrl.sv
// Testbench for tetris_game_ctrl: directed vector table, hand-written
// multi-cycle sequences and randomized stimulus against a queue-based
// reference model. A second instance with LINES_W=2 shares the stimulus
// to exercise lines saturation.

module tb_tetris_game_ctrl;

    localparam int ROWS = 12;
    localparam int RW   = 4;
    localparam int P    = 5;

    logic            clka = 1'b0;
    logic            restart = 1'b0, gen_ack = 1'b0, spawn_ok = 1'b0;
    logic            touched = 1'b0, clr_done = 1'b0;
    logic [ROWS-1:0] full_rows = '0;

    logic [2:0]      state, level;
    logic            board_clr, gen_req, drop_tick, clr_req, game_over;
    logic [RW-1:0]   clr_row;
    logic [7:0]      lines;

    logic [2:0]      s_state, s_level;
    logic            s_board_clr, s_gen_req, s_drop_tick, s_clr_req, s_game_over;
    logic [RW-1:0]   s_clr_row;
    logic [1:0]      s_lines;

    tetris_game_ctrl #(
        .ROWS(ROWS), .RW(RW), .GRAV_W(16), .GRAV_PERIOD(P), .LINES_W(8)
    ) u_dut (
        .clka(clka), .restart(restart), .gen_ack(gen_ack), .spawn_ok(spawn_ok),
        .touched(touched), .full_rows(full_rows), .clr_done(clr_done),
        .state(state), .board_clr(board_clr), .gen_req(gen_req),
        .drop_tick(drop_tick), .clr_req(clr_req), .clr_row(clr_row),
        .lines(lines), .level(level), .game_over(game_over)
    );

    tetris_game_ctrl #(
        .ROWS(ROWS), .RW(RW), .GRAV_W(16), .GRAV_PERIOD(P), .LINES_W(2)
    ) u_sat (
        .clka(clka), .restart(restart), .gen_ack(gen_ack), .spawn_ok(spawn_ok),
        .touched(touched), .full_rows(full_rows), .clr_done(clr_done),
        .state(s_state), .board_clr(s_board_clr), .gen_req(s_gen_req),
        .drop_tick(s_drop_tick), .clr_req(s_clr_req), .clr_row(s_clr_row),
        .lines(s_lines), .level(s_level), .game_over(s_game_over)
    );

    // Free-running clock.
    always #5 clka = ~clka;

    typedef struct packed {
        logic            rst, ack, ok, tch;
        logic [ROWS-1:0] fr;
        logic            done;
    } in_t;

    typedef struct packed {
        in_t           i;
        logic [2:0]    st;
        logic          bclr, greq, tick, creq;
        logic [RW-1:0] crow;
        logic [7:0]    lines;
        logic          gover;
    } vec_t;

    int total = 0;
    int bad   = 0;

    // Reference model: game phase, cycles since MOVE entry, ordered queue of
    // rows still to clear, and an unbounded count of cleared rows.
    int m_st    = 0;
    int m_cnt   = 0;
    int m_lines = 0;
    int m_pend[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic logic [19:0] pack_out(input logic [2:0] st, input logic b, g, t, c,
                                             input logic [RW-1:0] r, input logic [7:0] l,
                                             input logic go);
        return {st, b, g, t, c, r, l, go};
    endfunction

    function automatic logic [19:0] dut_out();
        return pack_out(state, board_clr, gen_req, drop_tick, clr_req, clr_row, lines, game_over);
    endfunction

    function automatic logic [19:0] model_out();
        logic [RW-1:0] row;
        logic [7:0]    l;
        row = (m_pend.size() != 0) ? RW'(m_pend[0]) : '0;
        l   = (m_lines > 255) ? 8'd255 : 8'(m_lines);
        return pack_out(3'(m_st), m_st == 0, m_st == 1, (m_st == 2) && ((m_cnt % P) == P - 1),
                        m_st == 4, row, l, m_st == 5);
    endfunction

    task automatic model_step(input in_t v);
        if (v.rst) begin
            m_st = 0; m_cnt = 0; m_lines = 0; m_pend.delete();
        end else begin
            case (m_st)
                0: m_st = 1;
                1: if (v.ack) begin m_st = v.ok ? 2 : 5; m_cnt = 0; end
                2: if (v.tch) m_st = 3; else m_cnt++;
                3: begin
                    m_pend.delete();
                    for (int r = 0; r < ROWS; r++) if (v.fr[r]) m_pend.push_back(r);
                    m_st = (m_pend.size() == 0) ? 1 : 4;
                end
                4: if (v.done) begin
                    void'(m_pend.pop_front());
                    m_lines++;
                    if (m_pend.size() == 0) m_st = 1;
                end
                default: ;
            endcase
        end
    endtask

    // One clock: drive inputs, advance the model at the edge, compare #1 later.
    task automatic step(input in_t v);
        logic [1:0] sat_l;
        restart = v.rst; gen_ack = v.ack; spawn_ok = v.ok;
        touched = v.tch; full_rows = v.fr; clr_done = v.done;
        @(posedge clka);
        model_step(v);
        #1;
        check("model outputs", 32'(dut_out()), 32'(model_out()));
        sat_l = (m_lines > 3) ? 2'd3 : 2'(m_lines);
        check("sat state/lines", {27'd0, s_state, s_lines}, {27'd0, 3'(m_st), sat_l});
    endtask

    function automatic in_t mk_in(input logic rst, ack, ok, tch, input logic [ROWS-1:0] fr,
                                  input logic done);
        in_t v;
        v.rst = rst; v.ack = ack; v.ok = ok; v.tch = tch; v.fr = fr; v.done = done;
        return v;
    endfunction

    function automatic vec_t mk_vec(input in_t i, input logic [2:0] st,
                                    input logic bclr, greq, tick, creq,
                                    input logic [RW-1:0] crow, input logic [7:0] l,
                                    input logic gover);
        vec_t t;
        t.i = i; t.st = st; t.bclr = bclr; t.greq = greq; t.tick = tick;
        t.creq = creq; t.crow = crow; t.lines = l; t.gover = gover;
        return t;
    endfunction

    vec_t tbl[21];
    int   exp_rows[5] = '{0, 1, 4, 7, 11};

    // Main test sequence.
    initial begin
        in_t        idle, v;
        logic [16:0] ticks;
        idle = mk_in(0, 0, 0, 0, '0, 0);

        // Reset, start, first piece, gravity, touch on tick, multi-clear, no-clear, over.
        tbl[0]  = mk_vec(mk_in(1, 0, 0, 0, '0, 0),        0, 1, 0, 0, 0, 0, 0, 0);
        tbl[1]  = mk_vec(mk_in(1, 0, 0, 0, '0, 0),        0, 1, 0, 0, 0, 0, 0, 0);
        tbl[2]  = mk_vec(mk_in(1, 1, 1, 1, 12'hfff, 1),   0, 1, 0, 0, 0, 0, 0, 0);
        tbl[3]  = mk_vec(mk_in(0, 0, 0, 0, '0, 0),        1, 0, 1, 0, 0, 0, 0, 0);
        tbl[4]  = mk_vec(mk_in(0, 0, 0, 0, '0, 0),        1, 0, 1, 0, 0, 0, 0, 0);
        tbl[5]  = mk_vec(mk_in(0, 1, 1, 0, '0, 0),        2, 0, 0, 0, 0, 0, 0, 0);
        tbl[6]  = mk_vec(mk_in(0, 0, 0, 0, '0, 0),        2, 0, 0, 0, 0, 0, 0, 0);
        tbl[7]  = mk_vec(mk_in(0, 0, 0, 0, '0, 0),        2, 0, 0, 0, 0, 0, 0, 0);
        tbl[8]  = mk_vec(mk_in(0, 0, 0, 0, 12'hfff, 0),   2, 0, 0, 0, 0, 0, 0, 0);
        tbl[9]  = mk_vec(mk_in(0, 0, 0, 0, '0, 0),        2, 0, 0, 1, 0, 0, 0, 0);
        tbl[10] = mk_vec(mk_in(0, 0, 0, 1, 12'hfff, 0),   3, 0, 0, 0, 0, 0, 0, 0);
        tbl[11] = mk_vec(mk_in(0, 0, 0, 0, 12'h025, 0),   4, 0, 0, 0, 1, 0, 0, 0);
        tbl[12] = mk_vec(mk_in(0, 1, 1, 0, '0, 0),        4, 0, 0, 0, 1, 0, 0, 0);
        tbl[13] = mk_vec(mk_in(0, 0, 0, 1, '0, 1),        4, 0, 0, 0, 1, 2, 1, 0);
        tbl[14] = mk_vec(mk_in(0, 0, 0, 0, '0, 1),        4, 0, 0, 0, 1, 5, 2, 0);
        tbl[15] = mk_vec(mk_in(0, 0, 0, 0, '0, 1),        1, 0, 1, 0, 0, 0, 3, 0);
        tbl[16] = mk_vec(mk_in(0, 1, 1, 0, '0, 1),        2, 0, 0, 0, 0, 0, 3, 0);
        tbl[17] = mk_vec(mk_in(0, 0, 0, 1, '0, 0),        3, 0, 0, 0, 0, 0, 3, 0);
        tbl[18] = mk_vec(mk_in(0, 0, 0, 0, '0, 1),        1, 0, 1, 0, 0, 0, 3, 0);
        tbl[19] = mk_vec(mk_in(0, 1, 0, 0, '0, 0),        5, 0, 0, 0, 0, 0, 3, 1);
        tbl[20] = mk_vec(mk_in(0, 1, 1, 1, 12'hfff, 1),   5, 0, 0, 0, 0, 0, 3, 1);

        for (int i = 0; i < 21; i++) begin
            step(tbl[i].i);
            check($sformatf("vec%0d", i), 32'(dut_out()),
                  32'(pack_out(tbl[i].st, tbl[i].bclr, tbl[i].greq, tbl[i].tick, tbl[i].creq,
                               tbl[i].crow, tbl[i].lines, tbl[i].gover)));
        end

        // OVER holds for 100 cycles under arbitrary inputs, then restart recovers.
        for (int k = 0; k < 100; k++) begin
            v = mk_in(0, 1'($urandom), 1'($urandom), 1'($urandom), ROWS'($urandom), 1'($urandom));
            step(v);
        end
        check("over hold", {28'd0, state, game_over}, {28'd0, 3'd5, 1'b1});
        step(mk_in(1, 0, 0, 0, '0, 0));
        check("restart state", 32'(state), 32'd0);
        check("restart lines", 32'(lines), 32'd0);
        step(idle);

        // Gravity: ticks exactly at MOVE cycles 5, 10 and 15.
        ticks = '0;
        step(mk_in(0, 1, 1, 0, '0, 0));
        ticks[1] = drop_tick;
        for (int n = 2; n <= 16; n++) begin
            step(idle);
            ticks[n] = drop_tick;
        end
        check("tick pattern", 32'(ticks), 32'h0000_8420);

        // Five-row clear: topmost first, 8-bit lines counts 5, 2-bit saturates at 3.
        step(mk_in(0, 0, 0, 1, '0, 0));
        step(mk_in(0, 0, 0, 0, 12'b1000_1001_0011, 0));
        for (int k = 0; k < 5; k++) begin
            check($sformatf("clr_row %0d", k), 32'(clr_row), 32'(exp_rows[k]));
            step(mk_in(0, 0, 0, 0, '0, 1));
        end
        check("lines after 5", 32'(lines), 32'd5);
        check("sat lines", 32'(s_lines), 32'd3);
        check("gen after clear", 32'(state), 32'd1);

        // Restart in the middle of a clear empties the pending mask.
        step(mk_in(0, 1, 1, 0, '0, 0));
        step(mk_in(0, 0, 0, 1, '0, 0));
        step(mk_in(0, 0, 0, 0, 12'h0c0, 0));
        step(mk_in(0, 0, 0, 0, '0, 1));
        check("clr_req mid", 32'(clr_req), 32'd1);
        step(mk_in(1, 0, 0, 0, '0, 1));
        check("rst clr_req", 32'(clr_req), 32'd0);
        check("rst clr_row", 32'(clr_row), 32'd0);
        step(idle);
        step(mk_in(0, 1, 1, 0, '0, 0));
        step(mk_in(0, 0, 0, 1, '0, 0));
        step(mk_in(0, 0, 0, 0, '0, 0));
        check("empty mask gen", {28'd0, state, clr_req}, {28'd0, 3'd1, 1'b0});

        // Randomized play against the model.
        for (int k = 0; k < 3000; k++) begin
            v.ack  = ($urandom_range(0, 3) == 0);
            v.ok   = ($urandom_range(0, 7) != 0);
            v.tch  = ($urandom_range(0, 15) == 0);
            v.fr   = ROWS'($urandom & $urandom & $urandom);
            v.done = 1'($urandom);
            v.rst  = ($urandom_range(0, 499) == 0) || ((m_st == 5) && ($urandom_range(0, 9) == 0));
            step(v);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
